// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches one or two 16-bit words per instruction,
// holds the assembled instruction for execute, and handles branch redirects.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        dec_imm_valid,
  output logic [31:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_HI = 3'd1,
    FETCH_LO = 3'd2,
    HOLD     = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic        r_imm;
  logic        r_mem_req;
  logic [15:0] r_mem_addr;
  logic [31:0] r_instr;
  logic [15:0] r_instr_pc;
  logic        r_instr_valid;
  logic [15:0] r_retired;

  logic [15:0] w_pc_plus1;
  logic [15:0] w_pc_next;

  assign w_pc_plus1 = r_pc + 16'd1;
  assign w_pc_next  = r_pc + (r_imm ? 16'd2 : 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_imm         <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= RESET_PC;
      r_instr       <= 32'h0;
      r_instr_pc    <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_retired     <= 16'h0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FETCH_HI;
          r_mem_req  <= 1'b1;
          r_mem_addr <= r_pc;
        end
        FETCH_HI, FETCH_LO: begin
          if (redirect_valid) begin
            // An unacked request must still complete, so park in DRAIN on the old address.
            r_pc          <= redirect_target;
            r_instr_valid <= 1'b0;
            if (mem_ack) begin
              r_state    <= FETCH_HI;
              r_mem_addr <= redirect_target;
            end else begin
              r_state <= DRAIN;
            end
          end else if (mem_ack) begin
            if (r_state == FETCH_HI) begin
              r_instr[31:16] <= mem_rdata;
              r_instr_pc     <= r_pc;
              r_imm          <= dec_imm_valid;
              if (dec_imm_valid) begin
                r_state    <= FETCH_LO;
                r_mem_addr <= w_pc_plus1;
              end else begin
                r_instr[15:0] <= 16'h0;
                r_state       <= HOLD;
                r_mem_req     <= 1'b0;
                r_instr_valid <= 1'b1;
              end
            end else begin
              r_instr[15:0] <= mem_rdata;
              r_state       <= HOLD;
              r_mem_req     <= 1'b0;
              r_instr_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (instr_ready)
            r_retired <= r_retired + 16'd1;
          if (redirect_valid || instr_ready) begin
            r_state       <= FETCH_HI;
            r_mem_req     <= 1'b1;
            r_instr_valid <= 1'b0;
            r_pc          <= redirect_valid ? redirect_target : w_pc_next;
            r_mem_addr    <= redirect_valid ? redirect_target : w_pc_next;
          end
        end
        DRAIN: begin
          if (redirect_valid) begin
            r_pc <= redirect_target;
          end else if (mem_ack) begin
            r_state    <= FETCH_HI;
            r_mem_addr <= r_pc;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory model with two override words,
// decoder flags an immediate when the first word's top nibble is 0xA.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        dec_imm_valid;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] retired;

  logic [15:0] oa0, od0, oa1, od1;
  logic        oe0, oe1;

  int n_chk = 0;
  int n_bad = 0;

  fetch_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dec_imm_valid(dec_imm_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .retired(retired)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = {4'h3, mem_addr[11:0]};
    if (oe0 && mem_addr == oa0) mem_rdata = od0;
    if (oe1 && mem_addr == oa1) mem_rdata = od1;
  end
  assign dec_imm_valid = (mem_rdata[15:12] == 4'hA);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!instr_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("vld_wait", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 16'h0;
    oe0 = 1'b0; oe1 = 1'b0; oa0 = 16'h0; od0 = 16'h0; oa1 = 16'h0; od1 = 16'h0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_req",   {31'b0, mem_req},     32'd0);
    chk("rst_addr",  {16'b0, mem_addr},    32'd0);
    chk("rst_instr", instr,                32'd0);
    chk("rst_ipc",   {16'b0, instr_pc},    32'd0);
    chk("rst_vld",   {31'b0, instr_valid}, 32'd0);
    chk("rst_ret",   {16'b0, retired},     32'd0);

    // streaming, no immediates, always ack/ready
    mem_ack = 1'b1; instr_ready = 1'b1; rst = 1'b0;
    chk("idle_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    chk("first_req",  {31'b0, mem_req}, 32'd1);
    chk("first_addr", {16'b0, mem_addr}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      wait_valid(4);
      chk("seq_ipc",   {16'b0, instr_pc}, k);
      chk("seq_instr", instr, {16'h3000 | 16'(k), 16'h0});
      chk("seq_ret",   {16'b0, retired}, k);
      @(negedge clk);
    end

    // immediate instruction at 0
    oe0 = 1'b1; oa0 = 16'h0000; od0 = 16'hA000;
    oe1 = 1'b1; oa1 = 16'h0001; od1 = 16'h1234;
    mem_ack = 1'b1; instr_ready = 1'b0;
    do_reset();
    wait_valid(6);
    chk("imm_instr", instr, 32'hA0001234);
    chk("imm_ipc",   {16'b0, instr_pc}, 32'd0);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("imm_next_addr", {16'b0, mem_addr}, 32'h2);
    chk("imm_next_req",  {31'b0, mem_req}, 32'd1);
    chk("imm_ret",       {16'b0, retired}, 32'd1);

    // ack stall in FETCH_HI
    oe0 = 1'b0; oe1 = 1'b0;
    mem_ack = 1'b0;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", {16'b0, mem_addr}, 32'd0);
      chk("stall_req",  {31'b0, mem_req}, 32'd1);
      @(negedge clk);
    end
    mem_ack = 1'b1;
    chk("stall_addr4", {16'b0, mem_addr}, 32'd0);
    chk("stall_vld0",  {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stall_vld1",  {31'b0, instr_valid}, 32'd1);
    chk("stall_instr", instr, 32'h30000000);

    // redirect while FETCH_LO waits -> DRAIN
    oe0 = 1'b1; oa0 = 16'h0000; od0 = 16'hA000;
    mem_ack = 1'b1; instr_ready = 1'b0;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    chk("lo_addr", {16'b0, mem_addr}, 32'h1);
    mem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 16'h0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("drain_req",  {31'b0, mem_req}, 32'd1);
    chk("drain_addr", {16'b0, mem_addr}, 32'h1);
    chk("drain_vld",  {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("drain_addr2", {16'b0, mem_addr}, 32'h1);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("post_drain_addr", {16'b0, mem_addr}, 32'h0100);
    chk("post_drain_req",  {31'b0, mem_req}, 32'd1);
    wait_valid(4);
    chk("redir_ipc",   {16'b0, instr_pc}, 32'h0100);
    chk("redir_instr", instr, 32'h31000000);

    // pc wrap with an immediate at 0xFFFF
    oe0 = 1'b1; oa0 = 16'hFFFF; od0 = 16'hA0FF;
    oe1 = 1'b1; oa1 = 16'h0000; od1 = 16'h5678;
    mem_ack = 1'b1; instr_ready = 1'b0;
    do_reset();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_target = 16'hFFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("wrap_hi_addr", {16'b0, mem_addr}, 32'hFFFF);
    @(negedge clk);
    chk("wrap_lo_addr", {16'b0, mem_addr}, 32'h0000);
    @(negedge clk);
    chk("wrap_vld",   {31'b0, instr_valid}, 32'd1);
    chk("wrap_instr", instr, 32'hA0FF5678);
    chk("wrap_ipc",   {16'b0, instr_pc}, 32'hFFFF);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("wrap_next_addr", {16'b0, mem_addr}, 32'h0001);
    chk("wrap_next_req",  {31'b0, mem_req}, 32'd1);

    // redirect coinciding with ready, then reset during HOLD
    oe0 = 1'b0; oe1 = 1'b0;
    mem_ack = 1'b1; instr_ready = 1'b0;
    do_reset();
    wait_valid(4);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    wait_valid(4);
    chk("hold_ret", {16'b0, retired}, 32'd1);
    chk("hold_ipc", {16'b0, instr_pc}, 32'd1);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0040;
    @(negedge clk);
    instr_ready = 1'b0; redirect_valid = 1'b0;
    chk("rr_ret",  {16'b0, retired}, 32'd2);
    chk("rr_addr", {16'b0, mem_addr}, 32'h0040);
    chk("rr_vld",  {31'b0, instr_valid}, 32'd0);
    wait_valid(4);
    chk("rr_ipc", {16'b0, instr_pc}, 32'h0040);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld",   {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_ret",   {16'b0, retired}, 32'd0);
    chk("mid_rst_req",   {31'b0, mem_req}, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_req",  {31'b0, mem_req}, 32'd1);
    chk("restart_addr", {16'b0, mem_addr}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
